// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: builds one SD SPI-mode command frame, sends it through the
//   byte engine, then polls single bytes until an R1 arrives or the poll limit hits.
// Latency: CS_SETUP_CYCLES (+40 CRC cycles when SD_CMD_CRC7_EN is defined) to the
//   first spi_start. Backpressure: cmd_ready is high only in IDLE, and only one
//   engine transfer is outstanding at a time.
// Optional feature macro: SD_CMD_CRC7_EN (serial CRC7 over frame bytes 0..4).
// Ports: cmd_* = command request handshake; rsp_* = completion (pulse + held R1/timeout);
//   cs_n = card chip-select; spi_* = start/op/size/tx toward the engine,
//   addr/rx/rx_wr/done back from it.
module sd_cmd_sequencer #(
  parameter int ADDR_W          = 6,
  parameter int MAX_POLLS       = 8,
  parameter int CS_SETUP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_index,
  input  logic [31:0]       cmd_arg,
  output logic              rsp_valid,
  output logic [7:0]        rsp_r1,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              cs_n,
  output logic              spi_start,
  output logic              spi_op,
  output logic [ADDR_W-1:0] spi_size,
  input  logic [ADDR_W-1:0] spi_addr,
  output logic [7:0]        spi_tx_data,
  input  logic [7:0]        spi_rx_data,
  input  logic              spi_rx_wr,
  input  logic              spi_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
`ifdef SD_CMD_CRC7_EN
    ST_CRC,
`endif
    ST_SEND,
    ST_WAIT_SEND,
    ST_POLL,
    ST_WAIT_POLL,
    ST_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;        // shared by CS setup and CRC bit walk
  logic [7:0]  poll_q, poll_d;
  logic [47:0] frame_q, frame_d;    // byte0 in [47:40] ... byte5 in [7:0]
  logic [7:0]  rsp_r1_q, rsp_r1_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [7:0]  r1_new;
  logic [7:0]  byte5_init;
`ifdef SD_CMD_CRC7_EN
  logic [6:0]  crc_q, crc_d;
  logic [5:0]  bit_idx;
  logic        crc_fb;
`endif

  // Byte 5 loaded at accept; with CRC enabled it is overwritten when the CRC finishes.
  always_comb begin
    byte5_init = 8'h01;
`ifndef SD_CMD_CRC7_EN
    case (cmd_index)
      6'd0:    byte5_init = 8'h95;
      6'd8:    byte5_init = 8'h87;
      default: byte5_init = 8'h01;
    endcase
`endif
  end

  // A byte strobed in the same cycle as spi_done must drive the decision.
  assign r1_new = spi_rx_wr ? spi_rx_data : rsp_r1_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    poll_d        = poll_q;
    frame_d       = frame_q;
    rsp_r1_d      = rsp_r1_q;
    rsp_timeout_d = rsp_timeout_q;
`ifdef SD_CMD_CRC7_EN
    crc_d         = crc_q;
    bit_idx       = 6'd47 - cnt_q;
    crc_fb        = frame_q[bit_idx] ^ crc_q[6];
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          frame_d       = {2'b01, cmd_index, cmd_arg, byte5_init};
          rsp_timeout_d = 1'b0;
          cnt_d         = 6'd0;
`ifdef SD_CMD_CRC7_EN
          crc_d         = 7'd0;
`endif
          state_d       = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == 6'(CS_SETUP_CYCLES - 1)) begin
          cnt_d   = 6'd0;
`ifdef SD_CMD_CRC7_EN
          state_d = ST_CRC;
`else
          state_d = ST_SEND;
`endif
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
`ifdef SD_CMD_CRC7_EN
      ST_CRC: begin
        // x^7 + x^3 + 1, MSB-first over bytes 0..4, one bit per cycle.
        crc_d = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
        if (cnt_q == 6'd39) begin
          frame_d[7:0] = {crc_d, 1'b1};
          cnt_d        = 6'd0;
          state_d      = ST_SEND;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
`endif
      ST_SEND:      state_d = ST_WAIT_SEND;
      ST_WAIT_SEND: if (spi_done) state_d = ST_POLL;
      ST_POLL: begin
        if (poll_q != 8'hFF) poll_d = poll_q + 8'd1;
        state_d = ST_WAIT_POLL;
      end
      ST_WAIT_POLL: begin
        rsp_r1_d = r1_new;
        if (spi_done) begin
          if (!r1_new[7]) begin
            state_d = ST_FINISH;
          end else if (poll_q == 8'(MAX_POLLS)) begin
            rsp_timeout_d = 1'b1;
            state_d       = ST_FINISH;
          end else begin
            state_d = ST_POLL;
          end
        end
      end
      ST_FINISH: begin
        poll_d  = 8'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 6'd0;
      poll_q        <= 8'd0;
      frame_q       <= 48'hFFFF_FFFF_FFFF;
      rsp_r1_q      <= 8'hFF;
      rsp_timeout_q <= 1'b0;
`ifdef SD_CMD_CRC7_EN
      crc_q         <= 7'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      poll_q        <= poll_d;
      frame_q       <= frame_d;
      rsp_r1_q      <= rsp_r1_d;
      rsp_timeout_q <= rsp_timeout_d;
`ifdef SD_CMD_CRC7_EN
      crc_q         <= crc_d;
`endif
    end
  end

  // Outputs are pure functions of state so reset forces them all idle at once.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign cs_n        = (state_q == ST_IDLE) || (state_q == ST_FINISH);
  assign rsp_valid   = (state_q == ST_FINISH);
  assign spi_start   = (state_q == ST_SEND) || (state_q == ST_POLL);
  assign spi_op      = (state_q == ST_SEND);
  assign spi_size    = (state_q == ST_SEND) ? ADDR_W'(5) : ADDR_W'(0);
  assign rsp_r1      = rsp_r1_q;
  assign rsp_timeout = rsp_timeout_q;

  always_comb begin
    spi_tx_data = 8'hFF;
    case (spi_addr)
      ADDR_W'(0): spi_tx_data = frame_q[47:40];
      ADDR_W'(1): spi_tx_data = frame_q[39:32];
      ADDR_W'(2): spi_tx_data = frame_q[31:24];
      ADDR_W'(3): spi_tx_data = frame_q[23:16];
      ADDR_W'(4): spi_tx_data = frame_q[15:8];
      ADDR_W'(5): spi_tx_data = frame_q[7:0];
      default:    spi_tx_data = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
module tb_sd_cmd_sequencer;

  localparam int ADDR_W = 6;
  localparam int CS_CYC = 2;
`ifdef SD_CMD_CRC7_EN
  localparam int CRC_CYC = 40;
  localparam logic [7:0] CMD17_B5 = 8'h55;
  localparam logic [7:0] CMD55_B5 = 8'h65;
`else
  localparam int CRC_CYC = 0;
  localparam logic [7:0] CMD17_B5 = 8'h01;
  localparam logic [7:0] CMD55_B5 = 8'h01;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [5:0]        cmd_index = 6'd0;
  logic [31:0]       cmd_arg = 32'd0;
  logic              rsp_valid;
  logic [7:0]        rsp_r1;
  logic              rsp_timeout;
  logic              busy;
  logic              cs_n;
  logic              spi_start;
  logic              spi_op;
  logic [ADDR_W-1:0] spi_size;
  logic [ADDR_W-1:0] spi_addr = '0;
  logic [7:0]        spi_tx_data;
  logic [7:0]        spi_rx_data = 8'h00;
  logic              spi_rx_wr = 1'b0;
  logic              spi_done = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  sd_cmd_sequencer #(.ADDR_W(ADDR_W), .MAX_POLLS(8), .CS_SETUP_CYCLES(CS_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_r1(rsp_r1), .rsp_timeout(rsp_timeout), .busy(busy), .cs_n(cs_n),
    .spi_start(spi_start), .spi_op(spi_op), .spi_size(spi_size), .spi_addr(spi_addr),
    .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data), .spi_rx_wr(spi_rx_wr), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full command. Card answers FF for the first n_ff polls, then fin.
  // split: strobe the byte one cycle before spi_done (else same cycle).
  // hold: leave cmd_valid asserted for the whole transaction.
  task automatic do_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [47:0] frame, input int n_ff, input logic [7:0] fin,
                        input bit split, input bit hold, input logic [7:0] exp_r1,
                        input logic exp_to, input int exp_polls);
    int w;
    int polls;
    bit got;
    logic [7:0] b;
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    check({name, "_ready"}, cmd_ready, 1'b1);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    check({name, "_cs_low"}, cs_n, 1'b0);
    check({name, "_to_clr"}, rsp_timeout, 1'b0);
    w = 0;
    while (spi_start !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    check({name, "_send_start"}, spi_start, 1'b1);
    check({name, "_start_delay"}, w, CS_CYC + CRC_CYC);
    check({name, "_send_op"}, spi_op, 1'b1);
    check({name, "_send_size"}, spi_size, 5);
    @(negedge clk);
    for (int a = 0; a < 7; a++) begin
      spi_addr = ADDR_W'(a);
      #1;
      if (a < 6) check({name, "_byte"}, spi_tx_data, frame[47-8*a -: 8]);
      else       check({name, "_addr_oob"}, spi_tx_data, 8'hFF);
      @(negedge clk);
    end
    spi_addr = '0;
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    polls = 0;
    got   = 1'b0;
    for (int it = 0; it < 20 && !got; it++) begin
      w = 0;
      while (spi_start !== 1'b1 && rsp_valid !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
      end else if (spi_start === 1'b1) begin
        polls++;
        if (spi_op !== 1'b0 || spi_size !== '0) begin
          check({name, "_poll_opsize"}, {spi_op, spi_size}, 0);
        end
        @(negedge clk);
        b = (polls <= n_ff) ? 8'hFF : fin;
        spi_rx_data = b;
        spi_rx_wr   = 1'b1;
        if (split) begin
          @(negedge clk);
          spi_rx_wr   = 1'b0;
          spi_rx_data = 8'hFF;  // must not be captured
        end
        spi_done = 1'b1;
        @(negedge clk);
        spi_done  = 1'b0;
        spi_rx_wr = 1'b0;
      end else begin
        check({name, "_rsp_wait"}, rsp_valid, 1'b1);
        got = 1'b1;
      end
    end
    check({name, "_rsp_valid"}, rsp_valid, 1'b1);
    check({name, "_r1"}, rsp_r1, exp_r1);
    check({name, "_timeout"}, rsp_timeout, exp_to);
    check({name, "_polls"}, polls, exp_polls);
    check({name, "_cs_high"}, cs_n, 1'b1);
    if (hold) check({name, "_no_accept_finish"}, cmd_ready, 1'b0);
    @(negedge clk);
    check({name, "_idle_ready"}, cmd_ready, 1'b1);
    check({name, "_idle_busy"}, busy, 1'b0);
    check({name, "_pulse_one"}, rsp_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_start", spi_start, 1'b0);
    check("rst_op_size", {spi_op, spi_size}, 0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_r1", rsp_r1, 8'hFF);
    check("rst_timeout", rsp_timeout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd("cmd0", 6'd0, 32'h0, 48'h40_00_00_00_00_95, 1, 8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 2);
    do_cmd("cmd8", 6'd8, 32'h0000_01AA, 48'h48_00_00_01_AA_87, 0, 8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 1);
    do_cmd("cmd17", 6'd17, 32'h0, {40'h51_00_00_00_00, CMD17_B5}, 0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1);
    do_cmd("tmo", 6'd55, 32'h0, {40'h77_00_00_00_00, CMD55_B5}, 100, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 8);
    // Next accept clears the timeout flag (checked inside do_cmd).
    do_cmd("after_tmo", 6'd8, 32'h0000_01AA, 48'h48_00_00_01_AA_87, 0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1);

    // Reset during WAIT_SEND, then a late spi_done in IDLE.
    cmd_index = 6'd0;
    cmd_arg   = 32'h0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    begin
      int w = 0;
      while (spi_start !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    end
    check("mid_send_start", spi_start, 1'b1);
    @(negedge clk);
    check("mid_in_wait", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_ready", cmd_ready, 1'b1);
    check("mid_rst_cs", cs_n, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_r1", rsp_r1, 8'hFF);
    spi_done    = 1'b1;
    spi_rx_wr   = 1'b1;
    spi_rx_data = 8'h00;
    @(negedge clk);
    spi_done  = 1'b0;
    spi_rx_wr = 1'b0;
    check("late_done_busy", busy, 1'b0);
    check("late_done_start", spi_start, 1'b0);
    check("late_rx_r1", rsp_r1, 8'hFF);
    @(negedge clk);
    do_cmd("post_rst", 6'd0, 32'h0, 48'h40_00_00_00_00_95, 2, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 3);

    // cmd_valid held across a whole transaction: one accept, next only back in IDLE.
    do_cmd("hold1", 6'd0, 32'h0, 48'h40_00_00_00_00_95, 0, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1);
    do_cmd("hold2", 6'd8, 32'h0000_01AA, 48'h48_00_00_01_AA_87, 0, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Sequences one SD-card SPI-mode command transaction on top of the byte-level SPI engine.
- Accepts a command index and argument, then builds the 6-byte command frame and streams it out through the engine's write operation.
- Polls the card with single-byte reads until an R1 response arrives, or until the poll limit is reached.
- Owns chip-select, and sits between the card-init/block-transfer FSMs and the SPI engine.

Parameters:
- ADDR_W, 6, width of the engine's address and size fields (64-byte buffer).
- MAX_POLLS, 8, number of R1 poll bytes before timeout (N_CR limit); legal range 1..255.
- CS_SETUP_CYCLES, 2, clk cycles cs_n is held low before the first spi_start; legal range 1..15.

Ports:
- clk  in  1  system clock; the engine's sclk is derived from it.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request; held until accepted.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
- cmd_index  in  6  SD command number, sampled on accept.
- cmd_arg  in  32  command argument, sampled on accept.
- rsp_valid  out  1  one-cycle pulse when the transaction completes.
- rsp_r1  out  8  R1 byte; holds its value until the next accept.
- rsp_timeout  out  1  qualifies rsp_valid; holds its value until the next accept.
- busy  out  1  high whenever the FSM is not in IDLE.
- cs_n  out  1  card chip-select, active low.
- spi_start  out  1  one-cycle start pulse to the engine.
- spi_op  out  1  1 = write, 0 = read; valid while spi_start is high.
- spi_size  out  ADDR_W  last byte index: 5 for the frame, 0 for a poll.
- spi_addr  in  ADDR_W  byte index requested by the engine.
- spi_tx_data  out  8  frame byte selected by spi_addr; combinational.
- spi_rx_data  in  8  received byte from the engine.
- spi_rx_wr  in  1  received-byte strobe from the engine.
- spi_done  in  1  engine completion pulse.

Behaviour:
- Reset (synchronous, rst_n low at a clk edge), from any state including mid-frame:
  - state=IDLE, cs_n=1, spi_start=0, spi_op=0, spi_size=0, rsp_valid=0, rsp_r1=8'hFF, rsp_timeout=0, busy=0, poll counter=0.
  - Any engine transfer in flight is abandoned; a late spi_done or spi_rx_wr arriving in IDLE is ignored.
- Frame register, loaded on accept:
  - byte0 = {2'b01, cmd_index}
  - byte1..byte4 = cmd_arg[31:24], [23:16], [15:8], [7:0]
  - byte5 = {crc7, 1'b1}
  - spi_addr > 5 returns 8'hFF.
- States:
  - IDLE: cmd_ready=1. On accept: latch the frame, clear rsp_timeout, go to CS_SETUP.
  - CS_SETUP: cs_n=0; count CS_SETUP_CYCLES cycles, then go to CRC (macro defined) or SEND.
  - CRC: see Optional Feature.
  - SEND: pulse spi_start with spi_op=1, spi_size=5; go to WAIT_SEND next cycle.
  - WAIT_SEND: wait for spi_done, then go to POLL.
  - POLL: pulse spi_start with spi_op=0, spi_size=0; increment the poll counter; go to WAIT_POLL.
  - WAIT_POLL: capture spi_rx_data into rsp_r1 on spi_rx_wr. On spi_done:
    - if rsp_r1[7]==0, go to FINISH;
    - else if poll counter == MAX_POLLS, set rsp_timeout=1 and go to FINISH;
    - else return to POLL.
  - FINISH: cs_n=1; pulse rsp_valid; clear the poll counter; go to IDLE.
- cs_n stays low from CS_SETUP through WAIT_POLL inclusive.
- Simultaneous spi_rx_wr and spi_done in the same cycle: capture first; the decision uses the newly captured byte.
- Latency, no timeouts: at most one spi_start is outstanding at any time.
- spi_done received in any state other than WAIT_SEND or WAIT_POLL is ignored.
- Counters saturate; none wraps.

Optional Feature:
- Macro: SD_CMD_CRC7_EN.
- Defined:
  - CRC state computes CRC7 (polynomial x^7+x^3+1, init 0) serially over frame bytes 0..4, MSB first.
  - One bit per clk, so CRC lasts exactly 40 cycles.
  - crc7 is then written into byte5[7:1].
- Undefined:
  - CRC state is absent; the FSM goes CS_SETUP→SEND directly.
  - byte5 is fixed per command: 8'h95 for index 0, 8'h87 for index 8, 8'h01 otherwise.

Test Plan:
- Without the macro, accept CMD0, arg 0 → engine sees bytes 40 00 00 00 00 95 with spi_size=5. Card answers FF, then 01 → rsp_valid with rsp_r1=8'h01, rsp_timeout=0, 2 polls issued, cs_n high after FINISH.
- Accept CMD8, arg 32'h000001AA → bytes 48 00 00 01 AA 87. First poll byte 05 → rsp_r1=8'h05, 1 poll issued.
- With SD_CMD_CRC7_EN, accept CMD17, arg 0 → bytes 51 00 00 00 00 55. The first spi_start occurs exactly 40 cycles after CS_SETUP ends.
- Card returns FF on every poll with MAX_POLLS=8 → exactly 8 read starts, then rsp_valid with rsp_timeout=1, rsp_r1=8'hFF.
- Assert rst_n low for one cycle during WAIT_SEND → next cycle: IDLE, cs_n=1, cmd_ready=1. A late spi_done is ignored, and a new command completes normally afterwards.
- Hold cmd_valid high through the whole transaction → exactly one accept. A second command is accepted only in the cycle after FINISH, i.e. the first cycle back in IDLE.
